// File: rtl/div_mod_pkg.sv
// Shared types and helpers for the iterative mod-3 / mod-5 divisibility checker.
//   state_t    : FSM states of the checker (IDLE, REDUCE, DONE)
//   MODE_MOD3  : mode encoding for a mod-3 test
//   MODE_MOD5  : mode encoding for a mod-5 test
//   mod_of()   : modulus selected by a mode bit
package div_mod_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REDUCE = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic MODE_MOD3 = 1'b0;
    localparam logic MODE_MOD5 = 1'b1;

    function automatic logic [2:0] mod_of(input logic mode);
        return (mode == MODE_MOD5) ? 3'd5 : 3'd3;
    endfunction

endpackage

// File: rtl/alt_digit_diff.sv
// One alternating-digit-sum reduction step, purely combinational.
//   val  in  DATA_LEN  value to reduce
//   mode in  1         MODE_MOD3: base-2 digits, MODE_MOD5: base-4 digits
//   diff out DATA_LEN  |E - O|, E/O = sum of even-/odd-index digits
// The operand is walked as 2-bit pairs and each pair feeds one term into the even
// sum and one into the odd sum, so a single pair of adder chains serves both moduli.
// Sums are kept at full DATA_LEN width; their maximum (3*DATA_LEN/4) always fits.
module alt_digit_diff
    import div_mod_pkg::*;
#(
    parameter int unsigned DATA_LEN = 8
) (
    input  logic [DATA_LEN-1:0] val,
    input  logic                mode,
    output logic [DATA_LEN-1:0] diff
);

    logic [DATA_LEN-1:0] e_sum;
    logic [DATA_LEN-1:0] o_sum;

    always_comb begin
        e_sum = '0;
        o_sum = '0;
        for (int i = 0; i < int'(DATA_LEN / 2); i++) begin
            if (mode == MODE_MOD5) begin
                // Pair i is base-4 digit i; its index parity picks the sum.
                if ((i % 2) == 0) begin
                    e_sum = e_sum + DATA_LEN'(val[2*i +: 2]);
                end else begin
                    o_sum = o_sum + DATA_LEN'(val[2*i +: 2]);
                end
            end else begin
                // Pair i holds base-2 digit 2i (even) and 2i+1 (odd).
                e_sum = e_sum + DATA_LEN'(val[2*i]);
                o_sum = o_sum + DATA_LEN'(val[2*i+1]);
            end
        end
        diff = (e_sum >= o_sum) ? (e_sum - o_sum) : (o_sum - e_sum);
    end

endmodule

// File: rtl/div_mod_iter_checker.sv
// Sequential divisibility checker: tests one unsigned operand for divisibility by 3 or 5,
// applying one alternating-digit-sum reduction per cycle until the value drops below
// the modulus.
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   in_valid   in   1         operand present
//   in_ready   out  1         block can accept an operand (IDLE only)
//   in_data    in   DATA_LEN  unsigned operand
//   in_mode    in   1         0 = mod 3, 1 = mod 5
//   out_valid  out  1         result present (DONE only)
//   out_ready  in   1         consumer accepts result
//   out_div    out  1         operand divisible by the selected modulus
//   out_iters  out  CNT_LEN   reduction steps performed, saturating
module div_mod_iter_checker
    import div_mod_pkg::*;
#(
    parameter int unsigned DATA_LEN = 8,
    parameter int unsigned CNT_LEN  = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] in_data,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_div,
    output logic [CNT_LEN-1:0]  out_iters
);

    state_t              state_q, state_d;
    logic [DATA_LEN-1:0] val_q, val_d;
    logic                mode_q, mode_d;
    logic [CNT_LEN-1:0]  iters_q, iters_d;
    logic                div_q, div_d;
    logic [DATA_LEN-1:0] reduced;

    alt_digit_diff #(
        .DATA_LEN (DATA_LEN)
    ) u_alt_digit_diff (
        .val  (val_q),
        .mode (mode_q),
        .diff (reduced)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= '0;
            mode_q  <= MODE_MOD3;
            iters_q <= '0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            mode_q  <= mode_d;
            iters_q <= iters_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        val_d     = val_q;
        mode_d    = mode_q;
        iters_d   = iters_q;
        div_d     = div_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    val_d   = in_data;
                    mode_d  = in_mode;
                    iters_d = '0;
                    state_d = REDUCE;
                end
            end
            REDUCE: begin
                if (val_q < DATA_LEN'(mod_of(mode_q))) begin
                    div_d   = (val_q == '0);
                    state_d = DONE;
                end else begin
                    val_d = reduced;
                    if (iters_q != {CNT_LEN{1'b1}}) begin
                        iters_d = iters_q + CNT_LEN'(1);
                    end
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_div   = div_q;
    assign out_iters = iters_q;

endmodule

// File: tb/tb_div_mod_iter_checker.sv
module tb_div_mod_iter_checker;

    localparam int DATA_LEN = 8;
    localparam int CNT_LEN  = 4;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [DATA_LEN-1:0] in_data = '0;
    logic                in_mode = 1'b0;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                out_div;
    logic [CNT_LEN-1:0]  out_iters;

    int n_checks = 0;
    int n_fails  = 0;

    div_mod_iter_checker #(
        .DATA_LEN (DATA_LEN),
        .CNT_LEN  (CNT_LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_div   (out_div),
        .out_iters (out_iters)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "simulation timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: repeatedly replace v by |alternating signed digit sum| in base 2 or 4.
    function automatic int ref_iters(input int d, input bit m);
        int v, it, s, k, t, base, modulus;
        v       = d;
        it      = 0;
        base    = m ? 4 : 2;
        modulus = m ? 5 : 3;
        while (v >= modulus) begin
            s = 0;
            k = 0;
            t = v;
            while (t > 0) begin
                s += ((k % 2) == 0) ? (t % base) : -(t % base);
                t /= base;
                k++;
            end
            v = (s < 0) ? -s : s;
            if (it < (1 << CNT_LEN) - 1) it++;
        end
        return it;
    endfunction

    // Latency counts clock edges from the accepting edge (inclusive) to out_valid.
    task automatic run_op(input logic [DATA_LEN-1:0] d, input logic m, input int delay,
                          output logic div, output int iters, output int lat);
        int guard;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_wait", int'(in_ready), 1);
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("out_valid_wait", int'(out_valid), 1);
        div   = out_div;
        iters = int'(out_iters);
        repeat (delay) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct {
        logic [DATA_LEN-1:0] data;
        logic                mode;
        logic                div;
        int                  iters;
        int                  lat;
    } vec_t;

    initial begin
        vec_t vecs[12];
        logic div;
        int   iters, lat, guard, exp_it;
        bit   m;

        vecs[0]  = '{8'd9,   1'b0, 1'b1, 1, 3};
        vecs[1]  = '{8'd10,  1'b0, 1'b0, 1, 3};
        vecs[2]  = '{8'd200, 1'b1, 1'b1, 2, 4};
        vecs[3]  = '{8'd255, 1'b1, 1'b1, 1, 3};
        vecs[4]  = '{8'd0,   1'b1, 1'b1, 0, 2};
        vecs[5]  = '{8'd0,   1'b0, 1'b1, 0, 2};
        vecs[6]  = '{8'd2,   1'b0, 1'b0, 0, 2};
        vecs[7]  = '{8'd4,   1'b1, 1'b0, 0, 2};
        vecs[8]  = '{8'd3,   1'b0, 1'b1, 1, 3};
        vecs[9]  = '{8'd5,   1'b1, 1'b1, 1, 3};
        vecs[10] = '{8'd6,   1'b0, 1'b1, 1, 3};
        vecs[11] = '{8'd255, 1'b0, 1'b1, 1, 3};

        // Reset values
        #3;
        check("rst_in_ready",  int'(in_ready),  1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_div",   int'(out_div),   0);
        check("rst_out_iters", int'(out_iters), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        foreach (vecs[i]) begin
            run_op(vecs[i].data, vecs[i].mode, 0, div, iters, lat);
            check($sformatf("vec%0d_div", i),   int'(div), int'(vecs[i].div));
            check($sformatf("vec%0d_iters", i), iters,     vecs[i].iters);
            check($sformatf("vec%0d_lat", i),   lat,       vecs[i].lat);
        end

        // Back-pressure: result held while out_ready is low; a new operand offered
        // meanwhile must wait and must not disturb the held result.
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd200;
        in_mode  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data  = 8'd10;
        in_mode  = 1'b0;
        guard    = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("hold_reach_valid", int'(out_valid), 1);
        for (int c = 0; c < 5; c++) begin
            check("hold_out_valid", int'(out_valid), 1);
            check("hold_out_div",   int'(out_div),   1);
            check("hold_out_iters", int'(out_iters), 2);
            check("hold_in_ready",  int'(in_ready),  0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_in_ready",  int'(in_ready),  1);
        check("release_out_valid", int'(out_valid), 0);
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard    = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("held_src_valid", int'(out_valid), 1);
        check("held_src_div",   int'(out_div),   0);
        check("held_src_iters", int'(out_iters), 1);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // out_ready high before out_valid must not skip the result
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd15;
        in_mode  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        guard    = 0;
        while (!out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("early_ready_valid", int'(out_valid), 1);
        check("early_ready_div",   int'(out_div),   1);
        @(negedge clk);
        out_ready = 1'b0;
        check("early_ready_consumed", int'(out_valid), 0);

        // Reset in the middle of a reduction
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'd200;
        in_mode  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_in_ready",  int'(in_ready),  1);
        check("midrst_out_iters", int'(out_iters), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            check("midrst_no_result", int'(out_valid), 0);
        end

        // Full sweep, both moduli, random mode order and consumer delay
        for (int i = 0; i < 256; i++) begin
            for (int j = 0; j < 2; j++) begin
                m = (j == 0) ? bit'($urandom_range(1)) : ~m;
                exp_it = ref_iters(i, m);
                run_op(DATA_LEN'(i), m, int'($urandom_range(2)), div, iters, lat);
                check($sformatf("sweep_div_%0d_m%0d", i, m), int'(div),
                      ((i % (m ? 5 : 3)) == 0) ? 1 : 0);
                check($sformatf("sweep_iters_%0d_m%0d", i, m), iters, exp_it);
                check($sformatf("sweep_lat_%0d_m%0d", i, m), lat, 2 + exp_it);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
